// File: rtl/axis_cap_pkg.sv
// Shared definitions for the AXI-Stream packet capture memory: ctrl-word
// bit positions, FSM states and a saturating length adder.
package axis_cap_pkg;

  localparam int CTL_KEEP_LSB = 0;
  localparam int CTL_KEEP_W   = 8;
  localparam int CTL_LAST     = 8;
  localparam int CTL_SOP      = 9;
  localparam int CTL_TRUNC    = 10;
  localparam int CTL_PKT_LSB  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } cap_state_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/cap_popcount.sv
// Combinational population count of a byte-enable vector.
module cap_popcount #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/axis_pkt_capture_mem.sv
// AXI-Stream slave that records every accepted beat into parallel data and
// ctrl memories, with packet/byte statistics and full/overflow tracking.
module axis_pkt_capture_mem
  import axis_cap_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16384,
  parameter int AW         = 14
) (
  input  logic                    rx_mac_aclk,
  input  logic                    reset,
  input  logic                    capture_en,
  input  logic                    capture_clr,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  input  logic [31:0]             mem_rd_address,
  output logic [31:0]             mem_axis_rctrl,
  output logic [DATA_WIDTH-1:0]   mem_axis_rdata,
  output logic [AW:0]             wr_count,
  output logic [31:0]             pkt_count,
  output logic [31:0]             byte_count,
  output logic [15:0]             last_pkt_len,
  output logic                    mem_full,
  output logic                    overflow
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int CW = $clog2(KW + 1);

  cap_state_t state_reg, state_next;

  logic [AW-1:0]  wr_ptr_reg;
  logic [AW:0]    wr_count_reg;
  logic [31:0]    pkt_count_reg;
  logic [31:0]    byte_count_reg;
  logic [15:0]    len_acc_reg;
  logic [15:0]    last_len_reg;
  logic           sop_reg;
  logic           overflow_reg;
  logic [31:0]    rctrl_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;

  logic [31:0]           ctrl_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [CW-1:0]   keep_pop;
  logic [7:0]      keep_ext;
  logic [31:0]     ctrl_word;
  logic [15:0]     len_sum;
  logic            accept;
  logic            at_last_addr;
  logic [AW-1:0]   rd_addr;
  logic            unused_rd_addr_bits;

  cap_popcount #(.W(KW), .CW(CW)) u_popcount (
    .bits  (s_axis_tkeep),
    .count (keep_pop)
  );

  // Keep field is 8 bits wide; narrower streams are zero-extended.
  genvar gi;
  generate
    for (gi = 0; gi < CTL_KEEP_W; gi++) begin : g_keep
      if (gi < KW) begin : g_bit
        assign keep_ext[gi] = s_axis_tkeep[gi];
      end else begin : g_pad
        assign keep_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign rd_addr             = mem_rd_address[AW-1:0];
  assign unused_rd_addr_bits = ^mem_rd_address[31:AW];

  assign s_axis_tready = (state_reg == RUN);
  assign at_last_addr  = (wr_ptr_reg == AW'(DEPTH - 1));
  // A clear or reset in the same cycle discards the beat entirely.
  assign accept        = s_axis_tvalid & s_axis_tready & ~capture_clr & ~reset;
  assign len_sum       = sat_add16(sop_reg ? 16'd0 : len_acc_reg, 16'(keep_pop));

  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTL_KEEP_LSB +: CTL_KEEP_W] = keep_ext;
    ctrl_word[CTL_LAST]                   = s_axis_tlast;
    ctrl_word[CTL_SOP]                    = sop_reg;
    ctrl_word[CTL_TRUNC]                  = at_last_addr & ~s_axis_tlast;
    ctrl_word[CTL_PKT_LSB +: 16]          = pkt_count_reg[15:0];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (capture_en) state_next = RUN;
      RUN: begin
        if (accept && at_last_addr) state_next = FULL;
        else if (!capture_en)       state_next = IDLE;
      end
      FULL:    state_next = FULL;
      default: state_next = IDLE;
    endcase
    if (capture_clr) state_next = IDLE;
  end

  always_ff @(posedge rx_mac_aclk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge rx_mac_aclk) begin
    if (reset || capture_clr) begin
      wr_ptr_reg     <= '0;
      wr_count_reg   <= '0;
      pkt_count_reg  <= '0;
      byte_count_reg <= '0;
      len_acc_reg    <= '0;
      last_len_reg   <= '0;
      sop_reg        <= 1'b1;
      overflow_reg   <= 1'b0;
    end else begin
      if (state_reg == FULL && capture_en && s_axis_tvalid) overflow_reg <= 1'b1;
      if (accept) begin
        wr_ptr_reg     <= wr_ptr_reg + AW'(1);
        wr_count_reg   <= wr_count_reg + (AW+1)'(1);
        byte_count_reg <= byte_count_reg + 32'(keep_pop);
        len_acc_reg    <= len_sum;
        sop_reg        <= s_axis_tlast;
        if (s_axis_tlast) begin
          last_len_reg  <= len_sum;
          pkt_count_reg <= pkt_count_reg + 32'd1;
        end
      end
    end
  end

  // Memory arrays have no reset so they map onto block RAM.
  always_ff @(posedge rx_mac_aclk) begin
    if (accept) begin
      ctrl_mem[wr_ptr_reg] <= ctrl_word;
      data_mem[wr_ptr_reg] <= s_axis_tdata;
    end
  end

  // Registered read; a same-cycle write to the same address returns old data.
  always_ff @(posedge rx_mac_aclk) begin
    if (reset) begin
      rctrl_reg <= '0;
      rdata_reg <= '0;
    end else begin
      rctrl_reg <= ctrl_mem[rd_addr];
      rdata_reg <= data_mem[rd_addr];
    end
  end

  assign mem_axis_rctrl = rctrl_reg;
  assign mem_axis_rdata = rdata_reg;
  assign wr_count       = wr_count_reg;
  assign pkt_count      = pkt_count_reg;
  assign byte_count     = byte_count_reg;
  assign last_pkt_len   = last_len_reg;
  assign mem_full       = (state_reg == FULL);
  assign overflow       = overflow_reg;

endmodule

// File: tb/tb_axis_pkt_capture_mem.sv
// Self-checking bench for axis_pkt_capture_mem against a transaction-level model.
module tb_axis_pkt_capture_mem;

  localparam int DW    = 64;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          reset, capture_en, capture_clr;
  logic [DW-1:0] tdata;
  logic [7:0]    tkeep;
  logic          tvalid, tlast, tready;
  logic [31:0]   mem_rd_address, rctrl;
  logic [DW-1:0] rdata;
  logic [AW:0]   wr_count;
  logic [31:0]   pkt_count, byte_count;
  logic [15:0]   last_pkt_len;
  logic          mem_full, overflow;

  always #5 clk = ~clk;

  axis_pkt_capture_mem #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .rx_mac_aclk    (clk),
    .reset          (reset),
    .capture_en     (capture_en),
    .capture_clr    (capture_clr),
    .s_axis_tdata   (tdata),
    .s_axis_tkeep   (tkeep),
    .s_axis_tvalid  (tvalid),
    .s_axis_tlast   (tlast),
    .s_axis_tready  (tready),
    .mem_rd_address (mem_rd_address),
    .mem_axis_rctrl (rctrl),
    .mem_axis_rdata (rdata),
    .wr_count       (wr_count),
    .pkt_count      (pkt_count),
    .byte_count     (byte_count),
    .last_pkt_len   (last_pkt_len),
    .mem_full       (mem_full),
    .overflow       (overflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_ctrl [DEPTH];
  logic [63:0] m_data [DEPTH];
  int          m_ptr, m_wr, m_acc;
  logic [31:0] m_pkt, m_bytes;
  logic [15:0] m_last_len;
  bit          m_sop, m_full, m_ovf, m_ready, m_accepted;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_ptr = 0; m_wr = 0; m_acc = 0; m_pkt = 0; m_bytes = 0;
    m_last_len = 0; m_sop = 1; m_full = 0; m_ovf = 0;
  endtask

  // One clock: predicts acceptance from the model, advances the model, checks tready.
  task automatic tick();
    bit acc;
    int pc, len;
    logic trunc;
    acc = tvalid && m_ready && !capture_clr && !reset;
    m_accepted = acc;
    @(posedge clk);
    if (reset || capture_clr) begin
      model_clear();
    end else begin
      if (m_full && capture_en && tvalid) m_ovf = 1;
      if (acc) begin
        pc    = $countones(tkeep);
        trunc = (m_ptr == DEPTH - 1) && !tlast;
        m_ctrl[m_ptr] = {m_pkt[15:0], 5'b0, trunc, m_sop, tlast, tkeep};
        m_data[m_ptr] = tdata;
        len = (m_sop ? 0 : m_acc) + pc;
        if (len > 65535) len = 65535;
        m_acc = len;
        if (tlast) begin
          m_last_len = len[15:0];
          m_pkt++;
        end
        m_bytes += pc;
        m_wr++;
        if (m_ptr == DEPTH - 1) m_full = 1;
        m_ptr = (m_ptr + 1) % DEPTH;
        m_sop = tlast;
      end
    end
    m_ready = capture_en && !reset && !capture_clr && !m_full;
    #1;
    chk("tready", 64'(tready), 64'(m_ready));
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_wr_count"},   64'(wr_count),     64'(m_wr));
    chk({tag, "_pkt_count"},  64'(pkt_count),    64'(m_pkt));
    chk({tag, "_byte_count"}, 64'(byte_count),   64'(m_bytes));
    chk({tag, "_last_len"},   64'(last_pkt_len), 64'(m_last_len));
    chk({tag, "_mem_full"},   64'(mem_full),     64'(m_full));
    chk({tag, "_overflow"},   64'(overflow),     64'(m_ovf));
    $display("counters %s: wr=%0d pkts=%0d bytes=%0d last_len=%0d full=%0b ovf=%0b",
             tag, wr_count, pkt_count, byte_count, last_pkt_len, mem_full, overflow);
  endtask

  task automatic check_entry(input int addr);
    mem_rd_address = addr;
    tvalid = 0;
    tick();
    chk("rd_ctrl", 64'(rctrl), 64'(m_ctrl[addr]));
    chk("rd_data", rdata, m_data[addr]);
    $display("readback addr=%0d ctrl=%08h data=%016h", addr, rctrl, rdata);
  endtask

  task automatic send_beat(input logic [7:0] keep, input logic last);
    bit done = 0;
    tdata = {$urandom, $urandom};
    tkeep = keep;
    tlast = last;
    tvalid = 1;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      done = m_accepted;
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted");
    end
    tvalid = 0;
    $display("beat keep=%02h last=%0b data=%016h", keep, last, tdata);
  endtask

  task automatic pulse_clr();
    capture_clr = 1;
    tick();
    capture_clr = 0;
  endtask

  initial begin
    int idx;
    reset = 1; capture_en = 0; capture_clr = 0;
    tdata = '0; tkeep = '0; tvalid = 0; tlast = 0; mem_rd_address = 0;
    model_clear();
    m_ready = 0;
    tick();
    tick();
    reset = 0;
    check_counters("reset");
    chk("reset_rctrl", 64'(rctrl), 64'h0);
    chk("reset_rdata", rdata, 64'h0);

    // 1514-byte packet: 189 full beats plus a 2-byte tail
    capture_en = 1;
    tick();
    for (int b = 0; b < 190; b++) send_beat(b == 189 ? 8'h03 : 8'hFF, b == 189);
    check_counters("pkt1514");
    chk("pkt1514_len", 64'(last_pkt_len), 64'd1514);
    check_entry(0);
    chk("pkt1514_e0", 64'(rctrl), 64'h0000_02FF);
    check_entry(189);
    chk("pkt1514_e189", 64'(rctrl), 64'h0000_0103);

    // Three 64-byte packets with random idle gaps
    pulse_clr();
    check_counters("clr1");
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 8; b++) begin
        idx = $urandom_range(0, 2);
        for (int g = 0; g < idx; g++) tick();
        send_beat(8'hFF, b == 7);
      end
    end
    check_counters("three_pkts");
    chk("three_byte_count", 64'(byte_count), 64'd192);
    check_entry(0);
    chk("three_e0", 64'(rctrl), 64'h0000_02FF);
    check_entry(8);
    chk("three_e8", 64'(rctrl), 64'h0001_02FF);
    check_entry(16);
    chk("three_e16", 64'(rctrl), 64'h0002_02FF);
    check_entry(5);

    // capture_en dropped mid-packet, then resumed
    pulse_clr();
    tick();
    for (int b = 0; b < 3; b++) send_beat(8'hFF, 1'b0);
    capture_en = 0;
    for (int i = 0; i < 3; i++) tick();
    capture_en = 1;
    send_beat(8'hFF, 1'b0);
    send_beat(8'hFF, 1'b1);
    check_counters("resume");
    check_entry(3);
    chk("resume_sop", 64'(rctrl[9]), 64'd0);

    // Clear in the same cycle as a valid beat
    tdata = {$urandom, $urandom}; tkeep = 8'hFF; tlast = 0; tvalid = 1;
    capture_clr = 1;
    tick();
    capture_clr = 0; tvalid = 0;
    check_counters("clr_beat");
    send_beat(8'h0F, 1'b0);
    check_entry(0);
    chk("clr_beat_sop", 64'(rctrl[9]), 64'd1);
    check_counters("after_clr_beat");

    // Reset mid-packet
    send_beat(8'hFF, 1'b0);
    reset = 1; tvalid = 1; tkeep = 8'hFF; tlast = 0;
    tick();
    reset = 0; tvalid = 0;
    check_counters("mid_reset");
    send_beat(8'h3C, 1'b0);
    check_entry(0);
    chk("reset_sop", 64'(rctrl[9]), 64'd1);

    // Fill memory with an over-long packet while tvalid stays high
    pulse_clr();
    idx = 0;
    tdata = {$urandom, $urandom}; tkeep = 8'($urandom_range(0, 255)); tlast = 0; tvalid = 1;
    for (int c = 0; c < DEPTH + 20; c++) begin
      tlast = (idx == DEPTH + 3);
      tick();
      if (m_accepted) begin
        idx++;
        tdata = {$urandom, $urandom};
        tkeep = 8'($urandom_range(0, 255));
      end
    end
    check_counters("full");
    chk("full_wr_count", 64'(wr_count), 64'(DEPTH));
    chk("full_flag", 64'(mem_full), 64'd1);
    chk("full_overflow", 64'(overflow), 64'd1);
    chk("full_pkt_count", 64'(pkt_count), 64'd0);
    check_entry(DEPTH - 1);
    chk("full_trunc", 64'(rctrl[10]), 64'd1);
    check_entry(DEPTH - 2);
    chk("full_no_trunc", 64'(rctrl[10]), 64'd0);
    pulse_clr();
    check_counters("full_clr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
